// File: rtl/tone_synth_pkg.sv
`default_nettype none
// ==================================================================
// tone_synth_pkg : FSM states, pitch half-period table and lookup. rev 1.0
// ==================================================================
package tone_synth_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  localparam logic [3:0] PITCH_REST = 4'd0;

  // Index 0 is C (pitch 1); values are half-periods in clocks at 100 kHz.
  localparam logic [11:0][7:0] PERIOD_TBL = {
    8'd101, 8'd107, 8'd114, 8'd120, 8'd128, 8'd135,
    8'd143, 8'd152, 8'd161, 8'd170, 8'd180, 8'd191
  };

  // Returns 0 for rests (pitch 0 and the unused codes 13..15).
  function automatic logic [7:0] half_period(input logic [3:0] pitch,
                                             input logic [1:0] octave);
    logic [7:0] h;
    h = 8'd0;
    if (pitch != PITCH_REST && pitch <= 4'd12) begin
      for (int i = 0; i < 12; i++) begin
        if (pitch == 4'(i + 1)) h = PERIOD_TBL[i] >> octave;
      end
    end
    return h;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ms_timer.sv
`default_nettype none
// ==================================================================
// ms_timer : tick prescaler with 1-cycle ms strobe and ms counter. rev 1.0
// ==================================================================
module ms_timer
  import tone_synth_pkg::*;
#(
  parameter int MS_W = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic [15:0]     ticks_per_milli,
  output logic            ms_strobe,
  output logic [MS_W-1:0] ms_count
);

  logic [15:0]     pre_q;
  logic [15:0]     tpm_q;
  logic [MS_W-1:0] cnt_q;
  logic [15:0]     w_tpm_eff;

  // Divisor is captured only at clear or wrap so a live change never
  // truncates the millisecond in progress.
  assign w_tpm_eff = (tpm_q == 16'd0) ? 16'd1 : tpm_q;
  assign ms_strobe = (pre_q == w_tpm_eff - 16'd1);
  assign ms_count  = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= 16'd0;
      tpm_q <= 16'd0;
      cnt_q <= '0;
    end else if (clear) begin
      pre_q <= 16'd0;
      tpm_q <= ticks_per_milli;
      cnt_q <= '0;
    end else if (ms_strobe) begin
      pre_q <= 16'd0;
      tpm_q <= ticks_per_milli;
      cnt_q <= cnt_q + MS_W'(1);
    end else begin
      pre_q <= pre_q + 16'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/tone_synth.sv
`default_nettype none
// ==================================================================
// tone_synth : note-to-square-wave FSM with ms-timed play/gap. rev 1.0
// ==================================================================
module tone_synth
  import tone_synth_pkg::*;
#(
  parameter int unsigned GAP_MS = 1,
  parameter int          MS_W   = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [15:0]     ticks_per_milli,
  input  logic            note_valid,
  output logic            note_ready,
  input  logic [3:0]      note_pitch,
  input  logic [1:0]      note_octave,
  input  logic [MS_W-1:0] note_ms,
  output logic            sound,
  output logic            playing,
  output logic            note_done
);

  localparam logic            c_has_gap  = (GAP_MS != 0);
  localparam logic [MS_W-1:0] c_gap_last = MS_W'(GAP_MS - 1);

  state_e          state_q;
  logic [7:0]      half_q;
  logic [7:0]      tone_q;
  logic            rest_q;
  logic [MS_W-1:0] ms_q;
  logic            sound_q;
  logic            playing_q;
  logic            done_q;

  logic [7:0]      half_d;
  logic            w_ms_strobe;
  logic [MS_W-1:0] w_ms_count;
  logic            w_play_end;
  logic            w_gap_end;
  logic            w_timer_clear;

  assign half_d     = half_period(note_pitch, note_octave);
  assign w_play_end = (state_q == ST_PLAY) && w_ms_strobe && (w_ms_count == ms_q - MS_W'(1));
  assign w_gap_end  = (state_q == ST_GAP) && w_ms_strobe && (w_ms_count == c_gap_last);
  // Holding the timer clear in IDLE makes every PLAY/GAP entry start from zero.
  assign w_timer_clear = (state_q == ST_IDLE) || w_play_end || w_gap_end;

  ms_timer #(
    .MS_W(MS_W)
  ) u_ms_timer (
    .clk            (clk),
    .rst_n          (rst_n),
    .clear          (w_timer_clear),
    .ticks_per_milli(ticks_per_milli),
    .ms_strobe      (w_ms_strobe),
    .ms_count       (w_ms_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      half_q    <= 8'd0;
      tone_q    <= 8'd0;
      rest_q    <= 1'b0;
      ms_q      <= '0;
      sound_q   <= 1'b0;
      playing_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          sound_q <= 1'b0;
          if (note_valid) begin
            half_q <= half_d;
            rest_q <= (half_d == 8'd0);
            ms_q   <= note_ms;
            tone_q <= half_d - 8'd1;
            if (note_ms != '0) begin
              state_q   <= ST_PLAY;
              playing_q <= 1'b1;
            end else if (c_has_gap) begin
              state_q <= ST_GAP;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        ST_PLAY: begin
          if (w_play_end) begin
            state_q   <= c_has_gap ? ST_GAP : ST_IDLE;
            done_q    <= !c_has_gap;
            playing_q <= 1'b0;
            sound_q   <= 1'b0;
          end else if (tone_q == 8'd0) begin
            tone_q <= half_q - 8'd1;
          end else begin
            tone_q <= tone_q - 8'd1;
            // Toggle lands on the same edge the counter reaches 0.
            if (tone_q == 8'd1 && !rest_q) sound_q <= !sound_q;
          end
        end
        ST_GAP: begin
          sound_q <= 1'b0;
          if (w_gap_end) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign note_ready = (state_q == ST_IDLE);
  assign sound      = sound_q;
  assign playing    = playing_q;
  assign note_done  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_tone_synth.sv
`default_nettype none
// ==================================================================
// tb_tone_synth : scoreboard bench for tone_synth (GAP_MS=1). rev 1.0
// ==================================================================
module tb_tone_synth;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] ticks_per_milli = 16'd100;
  logic        note_valid = 1'b0;
  logic        note_ready;
  logic [3:0]  note_pitch = 4'd0;
  logic [1:0]  note_octave = 2'd0;
  logic [9:0]  note_ms = 10'd0;
  logic        sound;
  logic        playing;
  logic        note_done;

  tone_synth dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ticks_per_milli(ticks_per_milli),
    .note_valid     (note_valid),
    .note_ready     (note_ready),
    .note_pitch     (note_pitch),
    .note_octave    (note_octave),
    .note_ms        (note_ms),
    .sound          (sound),
    .playing        (playing),
    .note_done      (note_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    play;
    int    done;
    int    tog;
    int    first;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Monitor state: cycle offsets are relative to the accepting edge.
  bit active = 1'b0;
  int rel = 0;
  int play_cnt = 0;
  int tog_cnt = 0;
  int first_edge = -1;
  int outside = 0;
  bit prev_sound = 1'b0;
  bit prev_playing = 1'b0;
  int low_run = 0;
  int last_low_run = 0;
  int done_seen = 0;
  int done_target = 0;

  task automatic chk(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, want);
    end
  endtask

  task automatic push_exp(input string n, input int p, input int d, input int t, input int f);
    exp_t e;
    e.name = n; e.play = p; e.done = d; e.tog = t; e.first = f;
    exp_q.push_back(e);
    done_target++;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst_n) begin
      active       = 1'b0;
      prev_sound   = 1'b0;
      prev_playing = 1'b0;
      low_run      = 0;
    end else begin
      if (active) begin
        rel++;
        if (playing) play_cnt++;
        if (playing && (sound != prev_sound)) begin
          tog_cnt++;
          if (first_edge < 0) first_edge = rel;
        end
      end
      if (sound && !playing) outside++;
      if (playing && !prev_playing) last_low_run = low_run;
      low_run      = playing ? 0 : low_run + 1;
      prev_playing = playing;
      prev_sound   = sound;
      if (note_done) begin
        done_seen++;
        if (!active || exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got note_done=1 expected no pulse (rel %0d)", rel);
        end else begin
          e = exp_q.pop_front();
          chk({e.name, "_play_cycles"}, play_cnt, e.play);
          chk({e.name, "_done_cycle"}, rel, e.done);
          chk({e.name, "_toggles"}, tog_cnt, e.tog);
          chk({e.name, "_first_edge"}, first_edge, e.first);
        end
        active = 1'b0;
      end
      if (note_valid && note_ready) begin
        active     = 1'b1;
        rel        = 0;
        play_cnt   = 0;
        tog_cnt    = 0;
        first_edge = -1;
      end
    end
  end

  task automatic offer(input logic [3:0] p, input logic [1:0] o, input logic [9:0] ms);
    bit ok;
    ok          = 1'b0;
    note_pitch  = p;
    note_octave = o;
    note_ms     = ms;
    note_valid  = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (note_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got note_ready=0 for 3000 cycles expected 1");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      if (done_seen >= done_target) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got %0d dones expected %0d", done_seen, done_target);
    end
    #1;
  endtask

  initial begin : stimulus
    int base;
    #1 rst_n = 1'b0;
    #2;
    chk("reset_ready", int'(note_ready), 1);
    chk("reset_sound", int'(sound), 0);
    chk("reset_playing", int'(playing), 0);
    chk("reset_done", int'(note_done), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // pitch 10 (A, 114) >> 1 = 57: toggles at 57/114/171, gap 201..300
    push_exp("single", 200, 301, 3, 57);
    offer(4'd10, 2'd1, 10'd2);
    note_valid = 1'b0;
    wait_done();

    push_exp("rest", 300, 401, 0, -1);
    offer(4'd0, 2'd0, 10'd3);
    note_valid = 1'b0;
    wait_done();

    push_exp("zero_ms", 0, 101, 0, -1);
    offer(4'd5, 2'd0, 10'd0);
    note_valid = 1'b0;
    wait_done();

    // A: 191>>3 = 23 -> 23/46/69/92; B: 101>>2 = 25 -> 25/50/75/100
    push_exp("b2b_a", 100, 201, 4, 23);
    push_exp("b2b_b", 100, 201, 4, 25);
    offer(4'd1, 2'd3, 10'd1);
    offer(4'd12, 2'd2, 10'd1);
    note_valid = 1'b0;
    wait_done();
    chk("b2b_playing_low_cycles", last_low_run, 101);

    // ticks 0 acts as 1: PLAY 1..4, GAP 5, done at 6
    ticks_per_milli = 16'd0;
    push_exp("tpm_zero", 4, 6, 0, -1);
    offer(4'd3, 2'd0, 10'd4);
    note_valid = 1'b0;
    wait_done();
    ticks_per_milli = 16'd100;

    push_exp("pitch14", 100, 201, 0, -1);
    offer(4'd14, 2'd0, 10'd1);
    note_valid = 1'b0;
    wait_done();

    // C4 H=191 for 3 ms; inputs scrambled while busy must not matter
    push_exp("busy", 300, 401, 1, 191);
    offer(4'd1, 2'd0, 10'd3);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      note_pitch  = 4'(k + 3);
      note_octave = 2'(k);
      note_ms     = 10'd1;
      note_valid  = (k % 2 == 0);
      @(negedge clk);
      chk("busy_ready", int'(note_ready), 0);
    end
    note_valid = 1'b0;
    wait_done();

    // 114>>3 = 14: sound high over cycles 42..55, so reset lands on sound=1
    offer(4'd10, 2'd3, 10'd2);
    note_valid = 1'b0;
    repeat (49) @(posedge clk);
    #3;
    chk("pre_reset_sound", int'(sound), 1);
    chk("pre_reset_playing", int'(playing), 1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_sound", int'(sound), 0);
    chk("async_reset_playing", int'(playing), 0);
    chk("async_reset_done", int'(note_done), 0);
    chk("async_reset_ready", int'(note_ready), 1);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    base = done_seen;
    repeat (400) @(posedge clk);
    chk("no_done_after_reset", done_seen, base);
    chk("idle_after_reset", int'(note_ready), 1);

    chk("sound_outside_play", outside, 0);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
